sda_rx: RTL
===========

# sda_rx

- Serial receiver for the single-wire SDA bus; the receive end of the bit-banged SDA output path in the LC-3 system.
- Samples the bus, frames 8-bit characters (start bit, 8 data bits LSB first, stop bit, idle high) and presents each byte in a memory-mapped data register with a status register.
- Status register follows the LC-3 device-register style: bit 15 ready, bit 14 interrupt enable.

## Interface

Parameters:
- CLKS_PER_BIT, default 1000: clk cycles per bit period. Legal range 4..65535.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- SDA_BUS  in  1  bus line. Released (z) reads as 1 via the external pull-up.
- MDR  in  16  write data for status register loads.
- LD_SDARSR  in  1  one-cycle strobe; loads status control bits from MDR.
- RD_SDARDR  in  1  one-cycle strobe; the CPU has read SDARDR.
- SDARSR  out  16  status register:
  - [15] ready
  - [14] interrupt enable (IE)
  - [13] overrun, sticky
  - [12] framing error
  - [0] busy (state != IDLE)
  - all other bits 0
- SDARDR  out  16  received byte in [7:0]; [15:8] always 0.
- INT  out  1  SDARSR[15] & SDARSR[14], registered-free combinational AND.

## Operation

- Input path:
  - SDA_BUS passes through a 2-flop synchronizer; both flops reset to 1.
  - A third register holds the previous synchronized value for edge detection.
  - The line value used below is the synchronized value ("line").
- States: IDLE, START, DATA, STOP. A 16-bit down-counter `cnt` and a 3-bit bit index `idx` drive them.
- IDLE:
  - A falling edge on line (previous 1, current 0) moves to START and loads cnt = CLKS_PER_BIT/2 − 1 (integer division).
- START, on cnt == 0:
  - If line == 0: go to DATA, cnt = CLKS_PER_BIT − 1, idx = 0.
  - Otherwise it is a false start: return to IDLE; no flags change.
- DATA, on cnt == 0:
  - Shift line into the shift register at bit idx (LSB first) and reload cnt = CLKS_PER_BIT − 1.
  - If idx == 7, go to STOP; otherwise increment idx.
- STOP, on cnt == 0, this is frame completion. Always return to IDLE afterwards.
  - If ready == 0, or RD_SDARDR is asserted in the same cycle:
    - SDARDR[7:0] ← shift register.
    - ready ← 1.
    - framing error ← (line == 0).
  - Otherwise (ready still set): overrun ← 1. The new byte and its framing status are discarded, and SDARDR keeps the old byte.
- Ready clear: RD_SDARDR clears ready on the next edge, unless frame completion happens in the same cycle. In that case completion wins and ready stays 1.
- LD_SDARSR:
  - IE ← MDR[14].
  - If MDR[13] == 1, overrun ← 0 (write-1-to-clear).
  - Ready, framing error and busy are not writable.
  - If an overrun set and a write-1 clear happen in the same cycle, the set wins.
- After a framing error the line may still be low. A new frame starts only on a fresh falling edge.
- Reset, including mid-frame:
  - State IDLE, cnt = 0, idx = 0, shift register = 0.
  - Synchronizer flops = 1.
  - SDARSR = 0x0000, SDARDR = 0x0000, INT = 0.
  - A partially received frame is dropped.

## Timing

- Bus falling edge to START entry: 3 clk edges.
- START sampling occurs CLKS_PER_BIT/2 cycles after START entry.
- Each data bit is sampled CLKS_PER_BIT cycles after the previous sample, so samples land mid-bit.
- Ready, SDARDR and framing error update on the edge that takes the stop sample. INT follows in the same cycle.
- Last data-bit sample to ready: CLKS_PER_BIT cycles.
- Total latency from bus start edge to ready: 3 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles.
- RD_SDARDR takes effect in 1 cycle.
- LD_SDARSR takes effect in 1 cycle.

## Configuration

- Macro: SDA_RX_GLITCH_FILTER_EN.
- Defined:
  - A 3-sample majority filter follows the synchronizer. It holds the last 3 synchronized values, all reset to 1.
  - "line" becomes the majority vote, registered.
  - Any single-cycle glitch is suppressed.
  - Edge-to-START latency becomes 5 edges. All other timing is unchanged.
- Undefined: no filter; line is the raw synchronized value; 3-edge latency as above.

## Test plan

- CLKS_PER_BIT=16, frame 0xA5 with valid stop -> SDARDR=0x00A5, SDARSR=0x8000 at the expected stop-sample cycle; then RD_SDARDR -> SDARSR=0x0000 next cycle.
- Write MDR=0x4000 via LD_SDARSR, then receive 0x3C -> SDARSR=0xC000, INT=1; RD_SDARDR -> INT=0.
- Receive 0x11, do not read, receive 0x22 -> SDARDR=0x0011, SDARSR=0xA000; LD_SDARSR with MDR=0x2000 -> SDARSR=0x8000.
- Receive 0x55 with stop bit 0 -> SDARDR=0x0055, SDARSR=0x9000; next clean frame 0x01 after a read -> SDARSR=0x8000.
- Low pulse of 4 cycles (shorter than half a bit) on idle line -> busy for 8 cycles then IDLE, SDARSR=0x0000. With SDA_RX_GLITCH_FILTER_EN, a 1-cycle pulse never sets busy.
- Assert rst mid-DATA, then send a full frame 0x7E -> all outputs 0 after the reset edge; the following frame is received correctly as 0x007E.

Source files
------------

// File: rtl/sda_rx.sv
// sda_rx: single-wire SDA bus receiver with LC-3 style status/data registers.
// Frames are start bit, 8 data bits LSB first, stop bit; idle line is high.
// Optional feature macro: SDA_RX_GLITCH_FILTER_EN adds a 3-sample majority
// filter behind the synchronizer (edge-to-START latency grows from 3 to 5).

module sda_rx #(
    parameter int unsigned CLKS_PER_BIT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SDA_BUS,
    input  logic [15:0] MDR,
    input  logic        LD_SDARSR,
    input  logic        RD_SDARDR,
    output logic [15:0] SDARSR,
    output logic [15:0] SDARDR,
    output logic        INT
);

    localparam logic [15:0] HalfLoad = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FullLoad = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        ie_q, ie_d;
    logic        ovr_q, ovr_d;
    logic        fe_q, fe_d;

    logic sync1_q, sync2_q, prev_q;
    logic line;
    logic complete;

    // Only IE and the overrun clear bit of MDR are meaningful here.
    logic unused_mdr;
    assign unused_mdr = ^{MDR[15], MDR[12:0]};

    // Two-flop synchronizer plus previous-line register for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= SDA_BUS;
            sync2_q <= sync1_q;
            prev_q  <= line;
        end
    end

`ifdef SDA_RX_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       line_q;

    // Majority of the last three synchronized samples, registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
            line_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
            line_q <= (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
        end
    end

    assign line = line_q;
`else
    assign line = sync2_q;
`endif

    // Next-state logic for the framing FSM and the status/data registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        ready_d  = ready_q;
        ie_d     = ie_q;
        ovr_d    = ovr_q;
        fe_d     = fe_q;
        complete = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (prev_q && !line) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                end
            end
            StStart: begin
                if (cnt_q == 16'd0) begin
                    if (!line) begin
                        state_d = StData;
                        cnt_d   = FullLoad;
                        idx_d   = 3'd0;
                    end else begin
                        // False start: glitch shorter than half a bit.
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StData: begin
                if (cnt_q == 16'd0) begin
                    shift_d[idx_q] = line;
                    cnt_d          = FullLoad;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (cnt_q == 16'd0) begin
                    state_d  = StIdle;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (RD_SDARDR) begin
            ready_d = 1'b0;
        end

        if (LD_SDARSR) begin
            ie_d = MDR[14];
            if (MDR[13]) begin
                ovr_d = 1'b0;
            end
        end

        // Completion overrides a same-cycle read clear and a same-cycle W1C.
        if (complete) begin
            if (!ready_q || RD_SDARDR) begin
                data_d  = shift_q;
                ready_d = 1'b1;
                fe_d    = !line;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State register for FSM, datapath and status bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            ready_q <= 1'b0;
            ie_q    <= 1'b0;
            ovr_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ie_q    <= ie_d;
            ovr_q   <= ovr_d;
            fe_q    <= fe_d;
        end
    end

    assign SDARSR = {ready_q, ie_q, ovr_q, fe_q, 11'd0, state_q != StIdle};
    assign SDARDR = {8'd0, data_q};
    assign INT    = ready_q & ie_q;

endmodule
